hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 34 +++
 rtl/md_timer.sv | 56 +++++
 rtl/hazard_ctrl.sv | 118 +++++++++++
 tb/tb_hazard_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding codes,
// multiply/divide FSM state encoding and default latencies.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int DEF_MUL_LAT = 4;
    localparam int DEF_DIV_LAT = 32;
    localparam int MD_CNT_W    = 6;

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

    // MEM wins over WB because it holds the younger result.
    function automatic logic [1:0] fwd_sel(
        input logic       mem_we,
        input logic [4:0] mem_rd,
        input logic       wb_we,
        input logic [4:0] wb_rd,
        input logic [4:0] src
    );
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == src)) begin
            return FWD_MEM;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src)) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/md_timer.sv
// Multiply/divide stall timer: IDLE/MD_BUSY FSM with a down-counter that
// holds the pipeline for exactly LAT cycles and flags the final cycle.
module md_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic md_start_i,
    input  logic md_op_i,
    output logic md_busy_o,
    output logic md_done_o
);

    localparam logic [MD_CNT_W-1:0] MUL_LOAD = MD_CNT_W'(MUL_LAT - 1);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD = MD_CNT_W'(DIV_LAT - 1);

    md_state_e             state_q, state_d, state_eff;
    logic [MD_CNT_W-1:0]   md_cnt_q, md_cnt_d;

    always_comb begin
        // While reset is held the outputs decode as if the FSM were idle.
        state_eff = rst_ni ? state_q : IDLE;
        state_d   = state_q;
        md_cnt_d  = md_cnt_q;
        md_busy_o = 1'b0;
        md_done_o = 1'b0;
        if (state_eff == IDLE) begin
            if (md_start_i) begin
                md_busy_o = 1'b1;
                state_d   = MD_BUSY;
                md_cnt_d  = md_op_i ? DIV_LOAD : MUL_LOAD;
            end
        end else begin
            md_busy_o = 1'b1;
            md_cnt_d  = md_cnt_q - 1'b1;
            if (md_cnt_q <= MD_CNT_W'(1)) begin
                md_done_o = 1'b1;
                state_d   = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, mul/div stall and
// EX operand forwarding. Define HAZARD_PERF_EN to add stall/flush counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_uses_rs,
    input  logic       ID_uses_rt,
    input  logic [4:0] EX_rs,
    input  logic [4:0] EX_rt,
    input  logic       EX_RegWrite,
    input  logic       EX_mem_read,
    input  logic [4:0] EX_writereg_num,
    input  logic       MEM_RegWrite,
    input  logic [4:0] MEM_writereg_num,
    input  logic       WB_RegWrite,
    input  logic [4:0] WB_writereg_num,
    input  logic       branch_taken,
    input  logic       md_start,
    input  logic       md_op,
    output logic       PC_en,
    output logic       IFID_en,
    output logic       IFID_flush,
    output logic       IDEX_en,
    output logic       IDEX_flush,
    output logic       EXMEM_flush,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       md_busy,
    output logic       md_done
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    logic load_use;

    md_timer #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_timer (
        .clk        (clk),
        .rst_ni     (rst),
        .md_start_i (md_start),
        .md_op_i    (md_op),
        .md_busy_o  (md_busy),
        .md_done_o  (md_done)
    );

    assign load_use = EX_mem_read && EX_RegWrite && (EX_writereg_num != 5'd0) &&
                      ((ID_uses_rs && (ID_rs == EX_writereg_num)) ||
                       (ID_uses_rt && (ID_rt == EX_writereg_num)));

    // Priority: mul/div stall (also swallows a same-cycle branch), then branch
    // flush, then load-use bubble.
    always_comb begin
        PC_en       = 1'b1;
        IFID_en     = 1'b1;
        IFID_flush  = 1'b0;
        IDEX_en     = 1'b1;
        IDEX_flush  = 1'b0;
        EXMEM_flush = 1'b0;
        if (md_busy) begin
            PC_en       = 1'b0;
            IFID_en     = 1'b0;
            IDEX_en     = 1'b0;
            EXMEM_flush = 1'b1;
        end else if (branch_taken) begin
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
        end else if (load_use) begin
            PC_en      = 1'b0;
            IFID_en    = 1'b0;
            IDEX_flush = 1'b1;
        end
    end

    assign fwd_a = fwd_sel(MEM_RegWrite, MEM_writereg_num, WB_RegWrite, WB_writereg_num, EX_rs);
    assign fwd_b = fwd_sel(MEM_RegWrite, MEM_writereg_num, WB_RegWrite, WB_writereg_num, EX_rt);

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (!PC_en && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (IFID_flush && (flush_count_q != 32'hFFFF_FFFF)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-count reference model.
module tb_hazard_ctrl;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] ID_rs, ID_rt, EX_rs, EX_rt;
    logic       ID_uses_rs, ID_uses_rt;
    logic       EX_RegWrite, EX_mem_read;
    logic [4:0] EX_writereg_num, MEM_writereg_num, WB_writereg_num;
    logic       MEM_RegWrite, WB_RegWrite;
    logic       branch_taken, md_start, md_op;
    logic       PC_en, IFID_en, IFID_flush, IDEX_en, IDEX_flush, EXMEM_flush;
    logic [1:0] fwd_a, fwd_b;
    logic       md_busy, md_done;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: stall cycles still owed after the current one.
    int md_left = 0;
    int m_stalls = 0;
    int m_flushes = 0;
    logic e_pc_en, e_ifid_en, e_ifid_flush, e_idex_en, e_idex_flush, e_exmem_flush;
    logic e_busy, e_done;
    logic [1:0] e_fwd_a, e_fwd_b;

    always #5 clk = ~clk;

    hazard_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk              (clk),
        .rst              (rst),
        .ID_rs            (ID_rs),
        .ID_rt            (ID_rt),
        .ID_uses_rs       (ID_uses_rs),
        .ID_uses_rt       (ID_uses_rt),
        .EX_rs            (EX_rs),
        .EX_rt            (EX_rt),
        .EX_RegWrite      (EX_RegWrite),
        .EX_mem_read      (EX_mem_read),
        .EX_writereg_num  (EX_writereg_num),
        .MEM_RegWrite     (MEM_RegWrite),
        .MEM_writereg_num (MEM_writereg_num),
        .WB_RegWrite      (WB_RegWrite),
        .WB_writereg_num  (WB_writereg_num),
        .branch_taken     (branch_taken),
        .md_start         (md_start),
        .md_op            (md_op),
        .PC_en            (PC_en),
        .IFID_en          (IFID_en),
        .IFID_flush       (IFID_flush),
        .IDEX_en          (IDEX_en),
        .IDEX_flush       (IDEX_flush),
        .EXMEM_flush      (EXMEM_flush),
        .fwd_a            (fwd_a),
        .fwd_b            (fwd_b),
        .md_busy          (md_busy),
        .md_done          (md_done)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cycles     (stall_cycles),
        .flush_count      (flush_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] src);
        if (MEM_RegWrite && MEM_writereg_num != 0 && MEM_writereg_num == src) return 2'b10;
        if (WB_RegWrite && WB_writereg_num != 0 && WB_writereg_num == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_outputs();
        logic lu;
        logic in_md;
        lu = EX_mem_read && EX_RegWrite && EX_writereg_num != 0 &&
             ((ID_uses_rs && ID_rs == EX_writereg_num) || (ID_uses_rt && ID_rt == EX_writereg_num));
        in_md = rst && (md_left > 0);
        {e_pc_en, e_ifid_en, e_idex_en} = 3'b111;
        {e_ifid_flush, e_idex_flush, e_exmem_flush} = 3'b000;
        e_busy = 1'b0;
        e_done = 1'b0;
        if (in_md || md_start) begin
            {e_pc_en, e_ifid_en, e_idex_en} = 3'b000;
            e_exmem_flush = 1'b1;
            e_busy = 1'b1;
            e_done = in_md && (md_left == 1);
        end else if (branch_taken) begin
            e_ifid_flush = 1'b1;
            e_idex_flush = 1'b1;
        end else if (lu) begin
            e_pc_en = 1'b0;
            e_ifid_en = 1'b0;
            e_idex_flush = 1'b1;
        end
        e_fwd_a = ref_fwd(EX_rs);
        e_fwd_b = ref_fwd(EX_rt);
    endtask

    task automatic check_all(input string step);
        model_outputs();
        chk({step, ".PC_en"}, 32'(PC_en), 32'(e_pc_en));
        chk({step, ".IFID_en"}, 32'(IFID_en), 32'(e_ifid_en));
        chk({step, ".IFID_flush"}, 32'(IFID_flush), 32'(e_ifid_flush));
        chk({step, ".IDEX_en"}, 32'(IDEX_en), 32'(e_idex_en));
        chk({step, ".IDEX_flush"}, 32'(IDEX_flush), 32'(e_idex_flush));
        chk({step, ".EXMEM_flush"}, 32'(EXMEM_flush), 32'(e_exmem_flush));
        chk({step, ".fwd_a"}, 32'(fwd_a), 32'(e_fwd_a));
        chk({step, ".fwd_b"}, 32'(fwd_b), 32'(e_fwd_b));
        chk({step, ".md_busy"}, 32'(md_busy), 32'(e_busy));
        chk({step, ".md_done"}, 32'(md_done), 32'(e_done));
`ifdef HAZARD_PERF_EN
        chk({step, ".stall_cycles"}, stall_cycles, 32'(m_stalls));
        chk({step, ".flush_count"}, flush_count, 32'(m_flushes));
`endif
        $display("step %s rst=%0b start=%0b br=%0b PC_en=%0b IFID_flush=%0b busy=%0b done=%0b fwd=%0d/%0d",
                 step, rst, md_start, branch_taken, PC_en, IFID_flush, md_busy, md_done, fwd_a, fwd_b);
    endtask

    // Check at mid-cycle, then advance one clock and update the model.
    task automatic cycle(input string step);
        #1;
        check_all(step);
        @(posedge clk);
        if (!rst) begin
            md_left = 0;
            m_stalls = 0;
            m_flushes = 0;
        end else begin
            if (!e_pc_en) m_stalls++;
            if (e_ifid_flush) m_flushes++;
            if (md_left > 0) md_left--;
            else if (md_start) md_left = (md_op ? DIV_LAT : MUL_LAT) - 1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        {ID_rs, ID_rt, EX_rs, EX_rt} = '0;
        {ID_uses_rs, ID_uses_rt, EX_RegWrite, EX_mem_read} = '0;
        {EX_writereg_num, MEM_writereg_num, WB_writereg_num} = '0;
        {MEM_RegWrite, WB_RegWrite, branch_taken, md_start, md_op} = '0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        @(posedge clk);
        #1;
        cycle("reset0");
        cycle("reset1");
        rst = 1'b1;
        cycle("idle");

        // Load-use on rs: one-cycle bubble, then the load has moved on.
        EX_mem_read = 1; EX_RegWrite = 1; EX_writereg_num = 8; ID_rs = 8; ID_uses_rs = 1;
        cycle("loaduse");
        chk("loaduse_PC_en_const", 32'(e_pc_en), 32'(0));
        EX_mem_read = 0; EX_RegWrite = 0;
        cycle("loaduse_after");
        chk("loaduse_after_PC_en", 32'(PC_en), 32'(1));

        // Forwarding priority.
        MEM_RegWrite = 1; MEM_writereg_num = 5; WB_RegWrite = 1; WB_writereg_num = 5;
        EX_rs = 5; EX_rt = 0;
        cycle("fwd_mem");
        chk("fwd_a_mem", 32'(fwd_a), 32'(2'b10));
        EX_rs = 0;
        cycle("fwd_zero");
        chk("fwd_a_r0", 32'(fwd_a), 32'(2'b00));
        MEM_writereg_num = 6; EX_rt = 5;
        cycle("fwd_wb");
        chk("fwd_b_wb", 32'(fwd_b), 32'(2'b01));

        // Branch plus load-use: flush wins.
        EX_mem_read = 1; EX_RegWrite = 1; branch_taken = 1;
        cycle("br_lu");
        chk("br_lu_PC_en", 32'(PC_en), 32'(1));
        idle_inputs();

        // Divide: stall T..T+31, done at T+31, released at T+32.
        md_start = 1; md_op = 1; branch_taken = 1;
        cycle("div_T0");
        md_start = 0; branch_taken = 0;
        for (int k = 1; k <= 33; k++) begin
            if (k == 5) begin md_start = 1; branch_taken = 1; end
            if (k == 6) begin md_start = 0; branch_taken = 0; end
            if (k == 31) chk("div_done_T31", 32'(md_done), 32'(1));
            if (k == 30) chk("div_nodone_T30", 32'(md_done), 32'(0));
            if (k == 32) chk("div_release_T32", 32'(PC_en), 32'(1));
            cycle($sformatf("div_T%0d", k));
        end

        // Multiply aborted by reset at T+2.
        md_start = 1; md_op = 0;
        cycle("mul_T0");
        md_start = 0;
        cycle("mul_T1");
        rst = 0;
        cycle("mul_T2_rst");
        rst = 1;
        cycle("mul_T3");
        chk("mul_abort_busy", 32'(md_busy), 32'(0));

`ifdef HAZARD_PERF_EN
        // Counters: one multiply plus two branches from a clean reset.
        rst = 0;
        cycle("perf_rst");
        rst = 1;
        md_start = 1; md_op = 0;
        cycle("perf_mul");
        md_start = 0;
        for (int k = 0; k < 4; k++) cycle("perf_wait");
        branch_taken = 1;
        cycle("perf_br0");
        branch_taken = 0;
        cycle("perf_gap");
        branch_taken = 1;
        cycle("perf_br1");
        branch_taken = 0;
        #1;
        chk("perf_stall_cycles", stall_cycles, 32'd4);
        chk("perf_flush_count", flush_count, 32'd2);
        #1;
`endif

        // Random traffic over a small register space to provoke matches.
        for (int n = 0; n < 500; n++) begin
            ID_rs = 5'($urandom_range(0, 3));
            ID_rt = 5'($urandom_range(0, 3));
            EX_rs = 5'($urandom_range(0, 3));
            EX_rt = 5'($urandom_range(0, 3));
            ID_uses_rs = 1'($urandom);
            ID_uses_rt = 1'($urandom);
            EX_RegWrite = 1'($urandom);
            EX_mem_read = 1'($urandom);
            EX_writereg_num = 5'($urandom_range(0, 3));
            MEM_RegWrite = 1'($urandom);
            MEM_writereg_num = 5'($urandom_range(0, 3));
            WB_RegWrite = 1'($urandom);
            WB_writereg_num = 5'($urandom_range(0, 3));
            branch_taken = ($urandom_range(0, 5) == 0);
            md_start = ($urandom_range(0, 11) == 0);
            md_op = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 49) != 0);
            cycle($sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
